// File: rtl/classifier_pkg.sv
// Shared types and arithmetic helpers for the multi-class linear classifier.
// Helpers take runtime widths so one definition serves every parameterisation.
package classifier_pkg;

  localparam int SAT_W      = 128;
  localparam int EXT_W      = 32;
  localparam int MAX_WORD_W = 2048;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DECIDE
  } lc_state_e;

  // Width of an index able to address n items; never below one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Exact signed add clamped to the range of a w-bit two's-complement value.
  function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                                      input logic signed [SAT_W-1:0] b,
                                                      input int w);
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    lo  = ~hi;
    if (sum > hi) return hi;
    else if (sum < lo) return lo;
    else return sum;
  endfunction

  // Pull lane 'lane' (w bits) out of a packed word, sign- or zero-extended.
  function automatic logic signed [EXT_W-1:0] ext_lane(input logic [MAX_WORD_W-1:0] word,
                                                       input int lane,
                                                       input int w,
                                                       input logic sgn);
    logic [EXT_W-1:0] mask;
    logic [EXT_W-1:0] raw;
    mask = (EXT_W'(1) << w) - EXT_W'(1);
    raw  = EXT_W'(word >> (lane * w)) & mask;
    if (sgn && (((raw >> (w - 1)) & EXT_W'(1)) != '0)) raw = raw | ~mask;
    return $signed(raw);
  endfunction

endpackage

// File: rtl/lc_class_lane.sv
// One class of the classifier: coefficient RAM, bias, lane multipliers,
// adder tree and saturating accumulator.
module lc_class_lane import classifier_pkg::*; #(
  parameter int FEAT_DIM = 8192,
  parameter int LANES    = 16,
  parameter int FEAT_W   = 8,
  parameter int COEF_W   = 16,
  parameter int ACC_W    = 48,
  parameter int ROW_W    = 9
) (
  input  logic                      clk,
  input  logic                      coef_we,
  input  logic [ROW_W-1:0]          coef_row,
  input  logic [LANES*COEF_W-1:0]   coef_wdata,
  input  logic                      bias_we,
  input  logic [ACC_W-1:0]          bias_wdata,
  input  logic [ROW_W-1:0]          rd_row,
  input  logic [LANES*FEAT_W-1:0]   feat_word,
  input  logic                      feat_signed,
  input  logic                      clr,
  input  logic                      mul_en,
  input  logic                      acc_en,
  output logic signed [ACC_W-1:0]   score
);

  localparam int ROWS  = FEAT_DIM / LANES;
  localparam int FX_W  = FEAT_W + 1;
  localparam int PW    = FEAT_W + 1 + COEF_W;
  localparam int SUM_W = PW + clog2(LANES) + 1;

  logic [LANES*COEF_W-1:0]  mem [ROWS];
  logic [LANES*COEF_W-1:0]  coef_p1;
  logic signed [ACC_W-1:0]  bias_q;
  logic signed [FX_W-1:0]   feat_s [LANES];
  logic signed [COEF_W-1:0] coef_s [LANES];
  logic signed [PW-1:0]     prod_p2 [LANES];
  logic signed [SUM_W-1:0]  sum_p2;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_next;

  // Stage p0 -> p1: coefficient row read alongside the FIFO pop
  always_ff @(posedge clk) begin
    if (coef_we) mem[coef_row] <= coef_wdata;
    coef_p1 <= mem[rd_row];
  end

  always_ff @(posedge clk) begin
    if (bias_we) bias_q <= $signed(bias_wdata);
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign feat_s[g] = FX_W'(ext_lane(MAX_WORD_W'(feat_word), g, FEAT_W, feat_signed));
    assign coef_s[g] = $signed(coef_p1[g*COEF_W +: COEF_W]);
  end

  // Stage p1 -> p2: registered lane products
  always_ff @(posedge clk) begin
    if (mul_en) begin
      for (int i = 0; i < LANES; i++) begin
        prod_p2[i] <= PW'(feat_s[i]) * PW'(coef_s[i]);
      end
    end
  end

  always_comb begin
    sum_p2 = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_p2 = sum_p2 + SUM_W'(prod_p2[i]);
    end
  end

  assign acc_next = ACC_W'(sat_add(SAT_W'(acc_q), SAT_W'(sum_p2), ACC_W));

  // Stage p2 -> accumulator
  always_ff @(posedge clk) begin
    if (clr) acc_q <= '0;
    else if (acc_en) acc_q <= acc_next;
  end

  assign score = ACC_W'(sat_add(SAT_W'(acc_q), SAT_W'(bias_q), ACC_W));

endmodule

// File: rtl/linear_classifier_mc.sv
// Multi-class linear classifier: pulls feature words from a read FIFO, scores
// every class in parallel and reports the argmax class with a threshold flag.
module linear_classifier_mc import classifier_pkg::*; #(
  parameter int FEAT_DIM    = 8192,
  parameter int LANES       = 16,
  parameter int FEAT_W      = 8,
  parameter int COEF_W      = 16,
  parameter int NUM_CLASSES = 4,
  parameter int ACC_W       = 48,
  parameter logic signed [ACC_W-1:0] THRESH = 8192,
  localparam int CLS_W = clog2(NUM_CLASSES),
  localparam int ROW_W = clog2(FEAT_DIM / LANES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANES*FEAT_W-1:0]  rd_data,
  input  logic                     rd_empty,
  output logic                     rd_fifo,
  input  logic                     cfg_signed,
  input  logic                     coef_we,
  input  logic [CLS_W-1:0]         coef_class,
  input  logic [ROW_W-1:0]         coef_row,
  input  logic [LANES*COEF_W-1:0]  coef_wdata,
  input  logic                     bias_we,
  input  logic [ACC_W-1:0]         bias_wdata,
  output logic                     busy,
  output logic                     cfg_err,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [CLS_W-1:0]         class_id,
  output logic [ACC_W-1:0]         class_score,
  output logic                     above_thresh
);

  localparam int WORDS = FEAT_DIM / LANES;
  localparam int CNT_W = clog2(WORDS + 1);

  lc_state_e               state_q, state_d;
  logic [CNT_W-1:0]        req_cnt;
  logic                    sgn_q;
  logic                    vld_p1, vld_p2;
  logic                    start, drain_done, cfg_open;
  logic signed [ACC_W-1:0] score [NUM_CLASSES];
  logic signed [ACC_W-1:0] best_score;
  logic [CLS_W-1:0]        best_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    rd_fifo      = 1'b0;
    start        = 1'b0;
    drain_done   = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rd_empty) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        rd_fifo = !rd_empty && (req_cnt < CNT_W'(WORDS));
        if (req_cnt == CNT_W'(WORDS)) state_d = DRAIN;
      end
      DRAIN: begin
        if (!vld_p1 && !vld_p2) begin
          state_d    = DECIDE;
          drain_done = 1'b1;
        end
      end
      DECIDE: begin
        result_valid = 1'b1;
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_open = (state_q == IDLE);
  assign busy     = !cfg_open;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_cnt <= '0;
      sgn_q   <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      vld_p1 <= rd_fifo;
      vld_p2 <= vld_p1;
      if (start) begin
        req_cnt <= '0;
        sgn_q   <= cfg_signed;
      end else if (rd_fifo) begin
        req_cnt <= req_cnt + 1'b1;
      end
      if ((coef_we || bias_we) && !cfg_open) cfg_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_class
    lc_class_lane #(
      .FEAT_DIM (FEAT_DIM),
      .LANES    (LANES),
      .FEAT_W   (FEAT_W),
      .COEF_W   (COEF_W),
      .ACC_W    (ACC_W),
      .ROW_W    (ROW_W)
    ) u_lane (
      .clk         (clk),
      .coef_we     (coef_we && cfg_open && (coef_class == CLS_W'(g))),
      .coef_row    (coef_row),
      .coef_wdata  (coef_wdata),
      .bias_we     (bias_we && cfg_open && (coef_class == CLS_W'(g))),
      .bias_wdata  (bias_wdata),
      .rd_row      (req_cnt[ROW_W-1:0]),
      .feat_word   (rd_data),
      .feat_signed (sgn_q),
      .clr         (start),
      .mul_en      (vld_p1),
      .acc_en      (vld_p2),
      .score       (score[g])
    );
  end

  // Strict greater-than keeps the lowest index on ties
  always_comb begin
    best_score = score[0];
    best_id    = '0;
    for (int k = 1; k < NUM_CLASSES; k++) begin
      if (score[k] > best_score) begin
        best_score = score[k];
        best_id    = CLS_W'(k);
      end
    end
  end

  // Decision stage: registered once the accumulators have settled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      class_id     <= '0;
      class_score  <= '0;
      above_thresh <= 1'b0;
    end else if (drain_done) begin
      class_id     <= best_id;
      class_score  <= best_score;
      above_thresh <= (best_score > THRESH);
    end
  end

endmodule

// File: tb/tb_linear_classifier_mc.sv
// Directed bench for linear_classifier_mc (64 features, 4 classes) with a
// second 24-bit-accumulator instance sharing the stimulus for saturation.
module tb_linear_classifier_mc;

  localparam int FEAT_DIM = 64;
  localparam int LANES    = 16;
  localparam int WORDS    = FEAT_DIM / LANES;

  logic                clk = 1'b0;
  logic                reset;
  logic [127:0]        rd_data;
  logic                rd_empty;
  logic                rd_fifo, rd_fifo24;
  logic                cfg_signed;
  logic                coef_we;
  logic [1:0]          coef_class;
  logic [1:0]          coef_row;
  logic [255:0]        coef_wdata;
  logic                bias_we;
  logic [47:0]         bias_wdata;
  logic                busy, busy24;
  logic                cfg_err, cfg_err24;
  logic                result_valid, result_valid24;
  logic                result_ready;
  logic [1:0]          class_id, class_id24;
  logic signed [47:0]  class_score;
  logic signed [23:0]  class_score24;
  logic                above_thresh, above_thresh24;

  linear_classifier_mc #(
    .FEAT_DIM(FEAT_DIM), .LANES(LANES), .FEAT_W(8), .COEF_W(16),
    .NUM_CLASSES(4), .ACC_W(48), .THRESH(8192)
  ) dut (
    .clk(clk), .reset(reset), .rd_data(rd_data), .rd_empty(rd_empty), .rd_fifo(rd_fifo),
    .cfg_signed(cfg_signed), .coef_we(coef_we), .coef_class(coef_class), .coef_row(coef_row),
    .coef_wdata(coef_wdata), .bias_we(bias_we), .bias_wdata(bias_wdata), .busy(busy),
    .cfg_err(cfg_err), .result_valid(result_valid), .result_ready(result_ready),
    .class_id(class_id), .class_score(class_score), .above_thresh(above_thresh)
  );

  linear_classifier_mc #(
    .FEAT_DIM(FEAT_DIM), .LANES(LANES), .FEAT_W(8), .COEF_W(16),
    .NUM_CLASSES(4), .ACC_W(24), .THRESH(8192)
  ) dut24 (
    .clk(clk), .reset(reset), .rd_data(rd_data), .rd_empty(rd_empty), .rd_fifo(rd_fifo24),
    .cfg_signed(cfg_signed), .coef_we(coef_we), .coef_class(coef_class), .coef_row(coef_row),
    .coef_wdata(coef_wdata), .bias_we(bias_we), .bias_wdata(bias_wdata[23:0]), .busy(busy24),
    .cfg_err(cfg_err24), .result_valid(result_valid24), .result_ready(result_ready),
    .class_id(class_id24), .class_score(class_score24), .above_thresh(above_thresh24)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  int rdf_cnt = 0;
  int viol = 0;
  int last_pop = 0;
  int rise = 0;
  bit pop_s = 1'b0;
  bit gap_en = 1'b0;
  logic [127:0] fifo_q [$];

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Standard read FIFO: the word appears the cycle after the pop request
  always @(posedge clk) begin
    #1;
    if (pop_s) begin
      if (fifo_q.size() > 0) rd_data = fifo_q.pop_front();
      pops++;
    end
    rd_empty = (fifo_q.size() == 0) || (gap_en && ($urandom_range(0, 1) == 1));
  end

  always @(negedge clk) begin
    pop_s = rd_fifo;
    if (rd_fifo) begin
      rdf_cnt++;
      last_pop = cyc;
      if (rd_empty) viol++;
    end
  end

  task automatic write_coef_class(input int cls, input logic [15:0] val);
    for (int r = 0; r < WORDS; r++) begin
      @(negedge clk);
      coef_we    = 1'b1;
      coef_class = 2'(cls);
      coef_row   = 2'(r);
      coef_wdata = {LANES{val}};
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic write_bias(input int cls, input logic signed [47:0] val);
    @(negedge clk);
    bias_we    = 1'b1;
    coef_class = 2'(cls);
    bias_wdata = val;
    @(negedge clk);
    bias_we = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] f, input logic sgn);
    cfg_signed = sgn;
    for (int w = 0; w < WORDS; w++) fifo_q.push_back({LANES{f}});
  endtask

  task automatic wait_result(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (result_valid) begin
        ok   = 1'b1;
        rise = cyc;
        break;
      end
    end
    chk({tag, "_seen"}, 64'(ok), 1);
  endtask

  task automatic check_result(input string tag, input int exp_id, input longint exp_score,
                              input int exp_above);
    chk({tag, "_id"}, 64'(class_id), 64'(exp_id));
    chk({tag, "_score"}, class_score, exp_score);
    chk({tag, "_above"}, 64'(above_thresh), 64'(exp_above));
  endtask

  task automatic accept();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] f, input logic sgn,
                           input int exp_id, input longint exp_score, input int exp_above);
    push_frame(f, sgn);
    wait_result(tag);
    check_result(tag, exp_id, exp_score, exp_above);
    accept();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int p0;
    bit seen;
    reset = 1'b1; rd_data = '0; rd_empty = 1'b1; cfg_signed = 1'b0;
    coef_we = 1'b0; coef_class = '0; coef_row = '0; coef_wdata = '0;
    bias_we = 1'b0; bias_wdata = '0; result_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rd_fifo", 64'(rd_fifo), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_cfg_err", 64'(cfg_err), 0);
    chk("rst_valid", 64'(result_valid), 0);
    chk("rst_class_id", 64'(class_id), 0);
    chk("rst_score", class_score, 0);
    chk("rst_above", 64'(above_thresh), 0);

    // Class 2 weights 3, everything else zero; all-ones features
    write_coef_class(0, 16'd0);
    write_coef_class(1, 16'd0);
    write_coef_class(2, 16'd3);
    write_coef_class(3, 16'd0);
    for (int c = 0; c < 4; c++) write_bias(c, 48'sd0);
    rdf_cnt = 0; viol = 0;
    run_frame("basic", 8'h01, 1'b0, 2, 192, 0);
    chk("basic_pop_cycles", 64'(rdf_cnt), WORDS);
    chk("basic_latency", 64'(rise - last_pop), 4);

    // Random empty gaps must not change the answer
    gap_en = 1'b1; p0 = pops; viol = 0;
    run_frame("gaps", 8'h01, 1'b0, 2, 192, 0);
    gap_en = 1'b0;
    chk("gaps_pops", 64'(pops - p0), WORDS);
    chk("gaps_pop_on_empty", 64'(viol), 0);

    // Sign handling: 0xFF is -1 signed, 255 unsigned
    write_coef_class(0, 16'd1);
    write_coef_class(2, 16'd0);
    for (int c = 1; c < 4; c++) write_bias(c, -48'sd1000);
    run_frame("signed", 8'hFF, 1'b1, 0, -64, 0);
    run_frame("unsigned", 8'hFF, 1'b0, 0, 16320, 1);

    // Tie between classes 1 and 3 resolves to 1
    for (int c = 1; c < 4; c++) write_bias(c, 48'sd0);
    write_coef_class(1, 16'd2);
    write_coef_class(3, 16'd2);
    run_frame("tie", 8'h01, 1'b0, 1, 128, 0);

    // Saturation in the 24-bit instance, exact in the 48-bit one
    write_coef_class(0, 16'd0);
    write_coef_class(1, 16'd0);
    write_coef_class(3, 16'd0);
    write_coef_class(2, 16'h7FFF);
    push_frame(8'h7F, 1'b0);
    wait_result("sat");
    check_result("sat48", 2, 266330176, 1);
    chk("sat24_id", 64'(class_id24), 2);
    chk("sat24_score", class_score24, 8388607);
    chk("sat24_above", 64'(above_thresh24), 1);
    accept();

    // Backpressure: held result blocks the next frame
    write_coef_class(2, 16'd3);
    push_frame(8'h01, 1'b0);
    wait_result("bp_first");
    check_result("bp_first", 2, 192, 0);
    push_frame(8'h02, 1'b0);
    p0 = pops;
    repeat (50) @(negedge clk);
    chk("bp_no_pops", 64'(pops - p0), 0);
    chk("bp_valid_held", 64'(result_valid), 1);
    chk("bp_score_held", class_score, 192);
    accept();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("bp_restart", 64'(seen), 1);
    @(negedge clk);
    coef_we = 1'b1; coef_class = 2'd2; coef_row = 2'd0; coef_wdata = {LANES{16'd5}};
    @(negedge clk);
    coef_we = 1'b0;
    chk("busy_write_cfg_err", 64'(cfg_err), 1);
    wait_result("bp_second");
    check_result("bp_second", 2, 384, 0);
    accept();
    run_frame("ram_kept", 8'h01, 1'b0, 2, 192, 0);

    // Reset mid-frame clears outputs at once; coefficients survive
    push_frame(8'h01, 1'b0);
    p0 = pops;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pops - p0 >= 2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("mid_run_reached", 64'(seen), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_rd_fifo", 64'(rd_fifo), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_cfg_err", 64'(cfg_err), 0);
    chk("mid_rst_valid", 64'(result_valid), 0);
    chk("mid_rst_class_id", 64'(class_id), 0);
    chk("mid_rst_score", class_score, 0);
    chk("mid_rst_above", 64'(above_thresh), 0);
    @(posedge clk);
    #2;
    fifo_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_frame("after_rst", 8'h01, 1'b0, 2, 192, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
